// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM encoding and parity helper.
// Pure declarations; no latency or backpressure of its own.
package uart_tx_fifo_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    function automatic logic calc_parity(input logic data_xor, input int mode);
        logic p;
        case (mode)
            PAR_EVEN: p = data_xor;
            PAR_ODD:  p = ~data_xor;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous DEPTH x WIDTH FIFO, combinational read of the head entry, level-derived full/empty.
// Push is dropped when full and pop is dropped when empty; simultaneous push/pop keeps the level.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; a byte pushed into an idle, empty FIFO starts its start bit one edge later.
// in_ready is !full; frames go out back-to-back while the FIFO holds data.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int DEPTH        = 4
) (
    input  logic                    hwclk,
    input  logic                    rst_n,
    input  logic [DATA_BITS-1:0]    in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    tx,
    output logic                    busy,
    output logic                    tx_done,
    output logic [$clog2(DEPTH):0]  fifo_level
);

    localparam int  CW         = $clog2(CLKS_PER_BIT);
    localparam int  BW         = $clog2(DATA_BITS);
    localparam bit  HAS_PARITY = (PARITY != PAR_NONE);

    tx_state_t             state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [BW-1:0]         bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0]  shreg, shreg_n;
    logic                  par_bit, par_n;
    logic                  tx_n;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic                  bit_end;
    logic [DATA_BITS-1:0]  fifo_dout;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (hwclk),
        .rst_n (rst_n),
        .push  (in_valid),
        .wdata (in_data),
        .pop   (pop),
        .rdata (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign in_ready = !full;
    assign busy     = (state != ST_IDLE);
    assign bit_end  = (cnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        par_n     = par_bit;
        pop       = 1'b0;
        tx_done   = 1'b0;
        tx_n      = 1'b1;

        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shreg_n = shreg >> 1;
                    if (bit_idx == BW'(DATA_BITS - 1)) begin
                        bit_idx_n = '0;
                        state_n   = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_n = bit_idx + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                // bit_idx is reused to count stop bits
                if (bit_end) begin
                    cnt_n = '0;
                    if (bit_idx == BW'(STOP_BITS - 1)) begin
                        tx_done   = 1'b1;
                        bit_idx_n = '0;
                        if (!empty) begin
                            pop     = 1'b1;
                            state_n = ST_START;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        bit_idx_n = bit_idx + BW'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase

        if (pop) begin
            shreg_n = fifo_dout;
            par_n   = calc_parity(^fifo_dout, PARITY);
        end

        // The line level is registered from the next state so tx never glitches.
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shreg_n[0];
            ST_PARITY: tx_n = par_n;
            default:   tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            par_bit <= par_n;
            tx      <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: four transmitter instances (8N1, 8E1, 8O1, 7N2) at 4 clocks per bit, depth 4.
module tb_uart_tx_fifo;

    logic       hwclk;
    logic       rst_n;
    logic [3:0] vld;
    logic [7:0] din [4];
    logic [3:0] rdy_v;
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [2:0] lvl [4];

    int errs;
    int checks;
    int ecnt;
    int done_cnt [4];

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    always @(posedge hwclk) begin
        ecnt++;
        for (int i = 0; i < 4; i++)
            if (done_v[i] === 1'b1) done_cnt[i]++;
    end

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) dut0 (
        .hwclk(hwclk), .rst_n(rst_n), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy_v[0]),
        .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]), .fifo_level(lvl[0]));

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DEPTH(4)) dut1 (
        .hwclk(hwclk), .rst_n(rst_n), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy_v[1]),
        .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]), .fifo_level(lvl[1]));

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH(4)) dut2 (
        .hwclk(hwclk), .rst_n(rst_n), .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy_v[2]),
        .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]), .fifo_level(lvl[2]));

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .DEPTH(4)) dut3 (
        .hwclk(hwclk), .rst_n(rst_n), .in_data(din[3][6:0]), .in_valid(vld[3]), .in_ready(rdy_v[3]),
        .tx(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]), .fifo_level(lvl[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    // Entered one step after the edge that starts the frame; returns one step after the edge ending it.
    task automatic run_frame(input int d, input logic [15:0] bits, input int nbits, input string tag);
        for (int c = 0; c < nbits * 4; c++) begin
            chk({tag, " tx"}, 32'(tx_v[d]), 32'(bits[c / 4]));
            chk({tag, " busy"}, 32'(busy_v[d]), 32'd1);
            chk({tag, " tx_done"}, 32'(done_v[d]), (c == nbits * 4 - 1) ? 32'd1 : 32'd0);
            tick();
        end
    endtask

    function automatic logic [15:0] f8n1(input logic [7:0] b);
        return {7'b0, 1'b1, b, 1'b0};
    endfunction

    logic [7:0] bytes3 [6];
    logic [7:0] bytes6 [4];
    int         acc [6];
    int         n;
    int         guard;
    logic       rdy;
    int         c0;

    initial begin
        errs   = 0;
        checks = 0;
        rst_n  = 1'b0;
        vld    = '0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        bytes3 = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'hC3};
        bytes6 = '{8'h12, 8'h34, 8'h56, 8'hE7};

        repeat (3) tick();
        chk("reset tx", 32'(tx_v[0]), 32'd1);
        chk("reset busy", 32'(busy_v[0]), 32'd0);
        chk("reset tx_done", 32'(done_v[0]), 32'd0);
        chk("reset in_ready", 32'(rdy_v[0]), 32'd1);
        chk("reset level", 32'(lvl[0]), 32'd0);
        rst_n = 1'b1;
        tick();

        // 8N1, 0x55
        vld[0] = 1'b1; din[0] = 8'h55;
        tick();
        vld[0] = 1'b0;
        chk("t1 level after push", 32'(lvl[0]), 32'd1);
        chk("t1 tx idle before start", 32'(tx_v[0]), 32'd1);
        chk("t1 busy before start", 32'(busy_v[0]), 32'd0);
        tick();
        chk("t1 level after pop", 32'(lvl[0]), 32'd0);
        run_frame(0, 16'h02AA, 10, "t1");
        chk("t1 tx after frame", 32'(tx_v[0]), 32'd1);
        chk("t1 busy after frame", 32'(busy_v[0]), 32'd0);
        chk("t1 done count", 32'(done_cnt[0]), 32'd1);

        // even and odd parity, 0xA5
        vld[2:1] = 2'b11; din[1] = 8'hA5; din[2] = 8'hA5;
        tick();
        vld[2:1] = 2'b00;
        tick();
        fork
            run_frame(1, 16'h054A, 11, "t2 even");
            run_frame(2, 16'h074A, 11, "t2 odd");
        join
        chk("t2 even busy after", 32'(busy_v[1]), 32'd0);
        chk("t2 odd busy after", 32'(busy_v[2]), 32'd0);

        // 7 data bits, 2 stop bits, 0x7F
        vld[3] = 1'b1; din[3] = 8'h7F;
        tick();
        vld[3] = 1'b0;
        tick();
        run_frame(3, 16'h03FE, 10, "t4");
        chk("t4 busy after", 32'(busy_v[3]), 32'd0);
        chk("t4 done count", 32'(done_cnt[3]), 32'd1);

        // six bytes with in_valid held high
        c0 = done_cnt[0];
        fork
            begin
                n = 0; guard = 0;
                vld[0] = 1'b1; din[0] = bytes3[0];
                while (n < 6 && guard < 200) begin
                    rdy = rdy_v[0];
                    tick();
                    guard++;
                    if (rdy) begin
                        acc[n] = ecnt;
                        n++;
                        if (n == 5) begin
                            chk("t3 in_ready after 5th", 32'(rdy_v[0]), 32'd0);
                            chk("t3 level full", 32'(lvl[0]), 32'd4);
                        end
                        if (n < 6) din[0] = bytes3[n];
                    end
                end
                vld[0] = 1'b0;
                chk("t3 accepts", 32'(n), 32'd6);
                chk("t3 5th accept edge", 32'(acc[4] - acc[0]), 32'd4);
                chk("t3 6th accept edge", 32'(acc[5] - acc[0]), 32'd42);
            end
            begin
                @(posedge hwclk);
                tick();
                for (int k = 0; k < 6; k++) run_frame(0, f8n1(bytes3[k]), 10, "t3");
            end
        join
        chk("t3 busy after", 32'(busy_v[0]), 32'd0);
        chk("t3 done pulses", 32'(done_cnt[0] - c0), 32'd6);

        // push and pop in the same cycle at level 2
        fork
            begin
                vld[0] = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    din[0] = bytes6[k];
                    tick();
                end
                vld[0] = 1'b0;
                repeat (38) tick();
                chk("t6 level before", 32'(lvl[0]), 32'd2);
                vld[0] = 1'b1; din[0] = bytes6[3];
                tick();
                vld[0] = 1'b0;
                chk("t6 level after push+pop", 32'(lvl[0]), 32'd2);
            end
            begin
                @(posedge hwclk);
                tick();
                for (int k = 0; k < 4; k++) run_frame(0, f8n1(bytes6[k]), 10, "t6");
            end
        join
        chk("t6 busy after", 32'(busy_v[0]), 32'd0);

        // reset mid-DATA with two bytes queued
        vld[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din[0] = bytes3[k + 2];
            tick();
        end
        vld[0] = 1'b0;
        repeat (8) tick();
        chk("t5 level queued", 32'(lvl[0]), 32'd2);
        chk("t5 busy mid frame", 32'(busy_v[0]), 32'd1);
        c0 = done_cnt[0];
        rst_n = 1'b0;
        tick();
        chk("t5 tx", 32'(tx_v[0]), 32'd1);
        chk("t5 busy", 32'(busy_v[0]), 32'd0);
        chk("t5 level", 32'(lvl[0]), 32'd0);
        chk("t5 in_ready", 32'(rdy_v[0]), 32'd1);
        chk("t5 tx_done", 32'(done_v[0]), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t5 no done pulse", 32'(done_cnt[0] - c0), 32'd0);
        chk("t5 idle tx", 32'(tx_v[0]), 32'd1);
        vld[0] = 1'b1; din[0] = 8'h96;
        tick();
        vld[0] = 1'b0;
        tick();
        run_frame(0, 16'h032C, 10, "t5 after reset");
        chk("t5 busy end", 32'(busy_v[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
